// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one external combinational 8-bit ALU between
// two valid/ready requesters and returns tagged results on one response channel.
module alu_share_arbiter #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic              last_grant_r;
    logic              id_r;
    logic              resp_valid_r;
    logic              resp_id_r;
    logic [DATA_W-1:0] resp_data_r;
    logic [DATA_W-1:0] alu_a_r;
    logic [DATA_W-1:0] alu_b_r;
    logic [OP_W-1:0]   alu_op_r;
    logic              busy_r;
    logic              grant0_s;
    logic              grant1_s;

    // Round-robin grant: on a tie the requester that did not win last time goes.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == IDLE) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (req0_valid) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Gating with rst_n keeps both readies low while reset is held.
    assign req0_ready = grant0_s & rst_n;
    assign req1_ready = grant1_s & rst_n;

    // Transaction FSM: capture winner, sample ALU one cycle later, hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            id_r         <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= 1'b0;
            resp_data_r  <= {DATA_W{1'b0}};
            alu_a_r      <= {DATA_W{1'b0}};
            alu_b_r      <= {DATA_W{1'b0}};
            alu_op_r     <= {OP_W{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant0_s || grant1_s) begin
                        alu_a_r      <= grant1_s ? req1_a  : req0_a;
                        alu_b_r      <= grant1_s ? req1_b  : req0_b;
                        alu_op_r     <= grant1_s ? req1_op : req0_op;
                        id_r         <= grant1_s;
                        last_grant_r <= grant1_s;
                        busy_r       <= 1'b1;
                        state_r      <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data_r  <= alu_result;
                    resp_id_r    <= id_r;
                    resp_valid_r <= 1'b1;
                    state_r      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_id    = resp_id_r;
    assign resp_data  = resp_data_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_op     = alu_op_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a vector table of single/tie transactions
// plus hand-written backpressure, mid-operation reset and starvation sequences.
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       resp_valid, resp_ready, resp_id;
    logic [7:0] resp_data, alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       busy;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(.DATA_W(8), .OP_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference ALU the arbiter drives.
    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = ~alu_a;
            3'b110:  alu_result = 8'h00;
            default: alu_result = alu_a + 8'h01;
        endcase
    end

    typedef struct {
        logic       v0;
        logic [7:0] a0;
        logic [7:0] b0;
        logic [2:0] op0;
        logic       v1;
        logic [7:0] a1;
        logic [7:0] b1;
        logic [2:0] op1;
        logic       exp_id;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with valids already driven; serves one transaction.
    task automatic serve(input logic exp_id, input logic [7:0] exp_data, input logic [1:0] drop);
        int waited = 0;
        #1;
        while (!(req0_ready || req1_ready) && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("grant_seen", {31'd0, req0_ready | req1_ready}, 32'd1);
        chk("grant_who", {30'd0, req1_ready, req0_ready}, exp_id ? 32'd2 : 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (drop[0]) req0_valid = 1'b0;
        if (drop[1]) req1_valid = 1'b0;
        #1;
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("exec_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(negedge clk);
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_data", {24'd0, resp_data}, {24'd0, exp_data});
        chk("resp_id", {31'd0, resp_id}, {31'd0, exp_id});
        @(negedge clk);
        chk("resp_done", {31'd0, resp_valid}, 32'd0);
        chk("idle_not_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bit seen_resp;
        vecs[0] = '{1'b1, 8'h05, 8'h03, 3'b000, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 8'h08};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 8'hFF, 8'h00, 3'b111, 1'b1, 8'h00};
        vecs[2] = '{1'b1, 8'h0F, 8'h3C, 3'b010, 1'b1, 8'h0F, 8'h3C, 3'b011, 1'b0, 8'h0C};
        vecs[3] = '{1'b1, 8'h0F, 8'h3C, 3'b010, 1'b1, 8'h0F, 8'h3C, 3'b011, 1'b1, 8'h3F};
        vecs[4] = '{1'b1, 8'h0F, 8'h3C, 3'b010, 1'b1, 8'h0F, 8'h3C, 3'b011, 1'b0, 8'h0C};
        vecs[5] = '{1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 8'hAA, 8'h55, 3'b100, 1'b1, 8'hFF};
        vecs[6] = '{1'b1, 8'h12, 8'h34, 3'b110, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00};
        vecs[7] = '{1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 8'hF0, 8'h20, 3'b000, 1'b1, 8'h10};

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h00; req0_op = 3'b000;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = 3'b000;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_resp", {29'd0, resp_valid, resp_id, busy}, 32'd0);
        chk("rst_alu", {13'd0, alu_op, alu_b, alu_a, 8'd0}, 32'd0);
        chk("rst_data", {24'd0, resp_data}, 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            req0_valid = vecs[i].v0; req0_a = vecs[i].a0; req0_b = vecs[i].b0; req0_op = vecs[i].op0;
            req1_valid = vecs[i].v1; req1_a = vecs[i].a1; req1_b = vecs[i].b1; req1_op = vecs[i].op1;
            serve(vecs[i].exp_id, vecs[i].exp_data, 2'b11);
        end

        // Backpressure: req0 SUB held in RESP while req1 waits.
        req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h01; req0_op = 3'b001;
        resp_ready = 1'b0;
        #1;
        chk("bp_ready0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'h00; req1_op = 3'b101;
        #1;
        chk("bp_exec_ready1", {31'd0, req1_ready}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_hold_data", {24'd0, resp_data}, 32'h0F);
            chk("bp_hold_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_after_hs_ready1", {31'd0, req1_ready}, 32'd1);
        serve(1'b1, 8'hF0, 2'b10);

        // Reset during EXEC aborts the transaction.
        req0_valid = 1'b1; req0_a = 8'hAA; req0_b = 8'h55; req0_op = 3'b100;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        #1;
        chk("mid_exec_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_alu", {13'd0, alu_op, alu_b, alu_a, 8'd0}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        rst_n = 1'b1;
        seen_resp = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid || busy) seen_resp = 1'b1;
        end
        chk("mid_rst_no_resp", {31'd0, seen_resp}, 32'd0);

        // Starvation: req0 held continuously, req1 raised once.
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; req0_op = 3'b000;
        req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'h00; req1_op = 3'b101;
        serve(1'b0, 8'h02, 2'b00);
        serve(1'b1, 8'hF0, 2'b10);
        serve(1'b0, 8'h02, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
